// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI responder: FSM states, mode decoding
// and synchronizer depth.
package spi_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } spi_state_e;

    function automatic logic mode_cpol(input logic [1:0] mode);
        return mode[1];
    endfunction

    function automatic logic mode_cpha(input logic [1:0] mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus a history flop that
// yields one-cycle rise/fall strobes of the synchronized level.
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter logic rst_val = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise_c,
    output logic fall_c
);

    logic [SYNC_STAGES-1:0] stages;
    logic                   prev;

    // Flops reset to the pin's idle level so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stages <= {SYNC_STAGES{rst_val}};
            prev   <= rst_val;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], din};
            prev   <= stages[SYNC_STAGES-1];
        end
    end

    assign sync   = stages[SYNC_STAGES-1];
    assign rise_c = sync & ~prev;
    assign fall_c = ~sync & prev;

endmodule

// File: rtl/spi_slave_rx_if.sv
// SPI responder: oversamples sclk/ss_n/mosi in the clk domain, receives
// bits_num-bit frames and returns a reply word from a one-entry holding buffer.
// Define SPI_LSB_FIRST_EN to transfer LSB first (default MSB first).
module spi_slave_rx_if
    import spi_pkg::*;
#(
    parameter logic [1:0]  mode     = 2'b00,
    parameter int unsigned bits_num = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sclk,
    input  logic                ss_n,
    input  logic                mosi,
    output logic                miso,
    output logic                miso_oe,
    input  logic [bits_num-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic [bits_num-1:0] rx_data,
    output logic                rx_valid,
    output logic                busy,
    output logic                frame_err,
    output logic                tx_underrun
);

    localparam logic            CPOL     = mode_cpol(mode);
    localparam logic            CPHA     = mode_cpha(mode);
    localparam int unsigned     CNT_W    = $clog2(bits_num);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(bits_num - 1);
`ifdef SPI_LSB_FIRST_EN
    localparam int unsigned     OUT_IDX  = 0;
`else
    localparam int unsigned     OUT_IDX  = bits_num - 1;
`endif

    spi_state_e             state;
    logic [CNT_W-1:0]       count;
    logic [bits_num-1:0]    rx_shift;
    logic [bits_num-1:0]    tx_shift;
    logic [bits_num-1:0]    hold;
    logic                   skip_shift;
    logic [SYNC_STAGES-1:0] mosi_stages;
    logic                   mosi_sync;
    logic                   sclk_sync, sclk_rise, sclk_fall;
    logic                   ss_sync, ss_rise, ss_fall;
    logic                   sclk_edge_c, lead_c, trail_c, sample_c, shift_c;
    logic                   accept_c;
    logic [bits_num-1:0]    rx_next_c, tx_next_c, load_word_c;

    spi_sync_edge #(.rst_val(CPOL)) u_sclk_sync (
        .clk    (clk),
        .reset  (reset),
        .din    (sclk),
        .sync   (sclk_sync),
        .rise_c (sclk_rise),
        .fall_c (sclk_fall)
    );

    spi_sync_edge #(.rst_val(1'b1)) u_ss_sync (
        .clk    (clk),
        .reset  (reset),
        .din    (ss_n),
        .sync   (ss_sync),
        .rise_c (ss_rise),
        .fall_c (ss_fall)
    );

    always_ff @(posedge clk) begin
        if (!reset) mosi_stages <= '0;
        else        mosi_stages <= {mosi_stages[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_sync = mosi_stages[SYNC_STAGES-1];

    // Leading edge leaves the idle level; trailing edge returns to it.
    assign sclk_edge_c = sclk_rise | sclk_fall;
    assign lead_c      = sclk_edge_c & (sclk_sync != CPOL);
    assign trail_c     = sclk_edge_c & (sclk_sync == CPOL);
    assign sample_c    = CPHA ? trail_c : lead_c;
    assign shift_c     = CPHA ? lead_c  : trail_c;

    assign accept_c    = tx_valid & tx_ready;
    assign load_word_c = tx_ready ? {bits_num{1'b0}} : hold;

`ifdef SPI_LSB_FIRST_EN
    assign rx_next_c = {mosi_sync, rx_shift[bits_num-1:1]};
    assign tx_next_c = {1'b0, tx_shift[bits_num-1:1]};
`else
    assign rx_next_c = {rx_shift[bits_num-2:0], mosi_sync};
    assign tx_next_c = {tx_shift[bits_num-2:0], 1'b0};
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            hold        <= '0;
            skip_shift  <= 1'b0;
            tx_ready    <= 1'b1;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
            miso_oe     <= ~ss_sync;

            unique case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (ss_rise) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        tx_shift    <= load_word_c;
                        miso        <= load_word_c[OUT_IDX];
                        tx_underrun <= tx_ready;
                        tx_ready    <= 1'b1;
                        skip_shift  <= CPHA;
                        count       <= '0;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        count     <= '0;
                        frame_err <= (count != '0);
                    end else if (sample_c) begin
                        rx_shift <= rx_next_c;
                        if (count == LAST_BIT) begin
                            rx_data     <= rx_next_c;
                            rx_valid    <= 1'b1;
                            count       <= '0;
                            // ss_n is still low here: reload for a back-to-back frame
                            // and swallow the shift edge that follows the last sample.
                            tx_shift    <= load_word_c;
                            miso        <= load_word_c[OUT_IDX];
                            tx_underrun <= tx_ready;
                            tx_ready    <= 1'b1;
                            skip_shift  <= 1'b1;
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end else if (shift_c) begin
                        if (skip_shift) begin
                            skip_shift <= 1'b0;
                        end else begin
                            tx_shift <= tx_next_c;
                            miso     <= tx_next_c[OUT_IDX];
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Placed after the FSM so a same-cycle LOAD sees the buffer empty first.
            if (accept_c) begin
                hold     <= tx_data;
                tx_ready <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rx_if.sv
// Directed bench for spi_slave_rx_if: one instance in mode 00, one in mode 11,
// driven by a bit-banged SPI master at f_clk = 10 x f_sclk.
module tb_spi_slave_rx_if;

    localparam int HALF = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sclk, ss_n, mosi, miso, miso_oe;
    logic [1:0] tx_valid, tx_ready, rx_valid, busy, frame_err, tx_underrun;
    logic [7:0] tx_data [2];
    logic [7:0] rx_data [2];

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         rv_cnt [2] = '{0, 0};
    int         fe_cnt [2] = '{0, 0};
    int         ur_cnt [2] = '{0, 0};
    int         rv_cyc [2] = '{0, 0};
    int         last_sample_cyc [2] = '{0, 0};
    logic [7:0] rv_hist [2][8];

    always #5 clk = ~clk;

    spi_slave_rx_if #(.mode(2'b00), .bits_num(8)) u_m0 (
        .clk(clk), .reset(reset), .sclk(sclk[0]), .ss_n(ss_n[0]), .mosi(mosi[0]),
        .miso(miso[0]), .miso_oe(miso_oe[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .busy(busy[0]),
        .frame_err(frame_err[0]), .tx_underrun(tx_underrun[0])
    );

    spi_slave_rx_if #(.mode(2'b11), .bits_num(8)) u_m3 (
        .clk(clk), .reset(reset), .sclk(sclk[1]), .ss_n(ss_n[1]), .mosi(mosi[1]),
        .miso(miso[1]), .miso_oe(miso_oe[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .busy(busy[1]),
        .frame_err(frame_err[1]), .tx_underrun(tx_underrun[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse logger, sampled just after each rising clk edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (rx_valid[i] === 1'b1) begin
                rv_hist[i][rv_cnt[i] % 8] = rx_data[i];
                rv_cnt[i] = rv_cnt[i] + 1;
                rv_cyc[i] = cyc;
            end
            if (frame_err[i] === 1'b1)   fe_cnt[i] = fe_cnt[i] + 1;
            if (tx_underrun[i] === 1'b1) ur_cnt[i] = ur_cnt[i] + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] out_vec(input int i);
        return 32'({miso[i], miso_oe[i], tx_ready[i], rx_valid[i], busy[i],
                    frame_err[i], tx_underrun[i], rx_data[i]});
    endfunction

    localparam logic [31:0] RESET_VEC = 32'({7'b0010000, 8'h00});

    task automatic load_tx(input int idx, input logic [7:0] d);
        int k;
        tx_data[idx]  = d;
        tx_valid[idx] = 1'b1;
        k = 0;
        while (tx_ready[idx] !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("tx_accept_ready", 32'(tx_ready[idx]), 32'h1);
        @(negedge clk);
        tx_valid[idx] = 1'b0;
    endtask

    task automatic half_wait();
        repeat (HALF) @(negedge clk);
    endtask

    // Drives nbits of mo (MSB first) and captures miso on the master's sample edge.
    task automatic spi_frame(input int idx, input logic [15:0] mo, input int nbits,
                             output logic [15:0] mi);
        logic cpol, cpha;
        cpol = (idx == 1);
        cpha = (idx == 1);
        mi = '0;
        ss_n[idx] = 1'b0;
        if (!cpha) mosi[idx] = mo[nbits-1];
        repeat (2 * HALF) @(negedge clk);
        for (int b = nbits - 1; b >= 0; b--) begin
            if (cpha) mosi[idx] = mo[b];
            else begin
                mi = {mi[14:0], miso[idx]};
                last_sample_cyc[idx] = cyc;
            end
            sclk[idx] = ~cpol;
            half_wait();
            if (cpha) begin
                mi = {mi[14:0], miso[idx]};
                last_sample_cyc[idx] = cyc;
            end
            sclk[idx] = cpol;
            if (!cpha && b > 0) mosi[idx] = mo[b-1];
            half_wait();
        end
    endtask

    task automatic end_frame(input int idx);
        ss_n[idx] = 1'b1;
        mosi[idx] = 1'b0;
        repeat (2 * HALF) @(negedge clk);
    endtask

    initial begin
        logic [15:0] cap;
        int rv_base, fe_base, ur_base;

        reset = 1'b0;
        sclk = 2'b10;
        ss_n = 2'b11;
        mosi = 2'b00;
        tx_valid = 2'b00;
        tx_data[0] = 8'h00;
        tx_data[1] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_m00", out_vec(0), RESET_VEC);
        check("reset_m11", out_vec(1), RESET_VEC);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Mode 00: 0xAB in, 0xC8 out; tx_ready rises in LOAD.
        load_tx(0, 8'hC8);
        check("m00_ready_after_accept", 32'(tx_ready[0]), 32'h0);
        rv_base = rv_cnt[0];
        fork
            spi_frame(0, 16'h00AB, 8, cap);
            begin
                repeat (3) @(negedge clk);
                check("m00_busy_in_load", 32'(busy[0]), 32'h1);
                check("m00_ready_before_load", 32'(tx_ready[0]), 32'h0);
                @(negedge clk);
                check("m00_ready_after_load", 32'(tx_ready[0]), 32'h1);
            end
        join
        end_frame(0);
        check("m00_rx_pulses", 32'(rv_cnt[0] - rv_base), 32'd1);
        check("m00_rx_data", 32'(rx_data[0]), 32'hAB);
        check("m00_rx_latency", 32'(rv_cyc[0] - last_sample_cyc[0]), 32'd3);
        check("m00_miso", 32'(cap[7:0]), 32'hC8);
        check("m00_idle_oe_busy", 32'({miso_oe[0], busy[0]}), 32'h0);

        // Mode 11: 0xF5 in, 0x2A out.
        load_tx(1, 8'h2A);
        rv_base = rv_cnt[1];
        spi_frame(1, 16'h00F5, 8, cap);
        end_frame(1);
        check("m11_rx_pulses", 32'(rv_cnt[1] - rv_base), 32'd1);
        check("m11_rx_data", 32'(rx_data[1]), 32'hF5);
        check("m11_rx_latency", 32'(rv_cyc[1] - last_sample_cyc[1]), 32'd3);
        check("m11_miso", 32'(cap[7:0]), 32'h2A);

        // Back-to-back frames with ss_n held low for 16 bits.
        load_tx(0, 8'hB9);
        rv_base = rv_cnt[0];
        fork
            spi_frame(0, 16'h920D, 16, cap);
            begin
                repeat (30) @(negedge clk);
                load_tx(0, 8'h1E);
            end
        join
        end_frame(0);
        check("b2b_rx_pulses", 32'(rv_cnt[0] - rv_base), 32'd2);
        check("b2b_rx_first", 32'(rv_hist[0][rv_base % 8]), 32'h92);
        check("b2b_rx_second", 32'(rv_hist[0][(rv_base + 1) % 8]), 32'h0D);
        check("b2b_miso", 32'(cap), 32'hB91E);

        // Underrun: no reply word queued.
        ur_base = ur_cnt[0];
        fork
            spi_frame(0, 16'h0029, 8, cap);
            begin
                repeat (8) @(negedge clk);
                check("underrun_pulse", 32'(ur_cnt[0] - ur_base), 32'd1);
            end
        join
        end_frame(0);
        check("underrun_miso", 32'(cap[7:0]), 32'h00);
        check("underrun_rx_data", 32'(rx_data[0]), 32'h29);

        // Abort after 4 sclk cycles, then a clean frame.
        fe_base = fe_cnt[0];
        rv_base = rv_cnt[0];
        spi_frame(0, 16'h000A, 4, cap);
        end_frame(0);
        check("abort_frame_err", 32'(fe_cnt[0] - fe_base), 32'd1);
        check("abort_no_rx_valid", 32'(rv_cnt[0] - rv_base), 32'd0);
        check("abort_rx_held", 32'(rx_data[0]), 32'h29);
        check("abort_miso_oe", 32'(miso_oe[0]), 32'h0);
        spi_frame(0, 16'h00FE, 8, cap);
        end_frame(0);
        check("after_abort_rx", 32'(rx_data[0]), 32'hFE);
        check("after_abort_no_err", 32'(fe_cnt[0] - fe_base), 32'd1);

        // Reset for one clk after bit 5, then a clean frame.
        load_tx(0, 8'h3C);
        fe_base = fe_cnt[0];
        rv_base = rv_cnt[0];
        spi_frame(0, 16'h0015, 5, cap);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midreset_outputs", out_vec(0), RESET_VEC);
        ss_n[0] = 1'b1;
        mosi[0] = 1'b0;
        repeat (2 * HALF) @(negedge clk);
        check("midreset_no_frame_err", 32'(fe_cnt[0] - fe_base), 32'd0);
        check("midreset_no_rx_valid", 32'(rv_cnt[0] - rv_base), 32'd0);
        load_tx(0, 8'h3C);
        spi_frame(0, 16'h001E, 8, cap);
        end_frame(0);
        check("after_reset_rx", 32'(rx_data[0]), 32'h1E);
        check("after_reset_miso", 32'(cap[7:0]), 32'h3C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
